// File: rtl/ahb3lite_irq_arbiter_if.sv
// ahb3lite_irq_arbiter_if
//   Bundles the signals between the IRQ source bank, the round-robin arbiter
//   and the interrupt consumer.
//   Signals:
//     irq, edge_sel, irq_en   source bank -> arbiter (raw lines, mode, enables)
//     valid, id               arbiter -> consumer (offered/active vector)
//     ack                     consumer -> arbiter (accept offered vector)
//     eoi, eoi_id             consumer -> arbiter (end-of-interrupt strobe + id)
//     busy, eoi_err, pending  arbiter status
//   Modports:
//     master : the arbiter side (drives valid/id/busy/eoi_err/pending)
//     slave  : the environment side (sources and consumer)
interface ahb3lite_irq_arbiter_if #(
    parameter int unsigned IRQ_CNT = 240,
    parameter int unsigned ID_W    = $clog2(IRQ_CNT)
);
    logic [IRQ_CNT-1:0] irq;
    logic [IRQ_CNT-1:0] edge_sel;
    logic [IRQ_CNT-1:0] irq_en;
    logic               valid;
    logic [ID_W-1:0]    id;
    logic               ack;
    logic               eoi;
    logic [ID_W-1:0]    eoi_id;
    logic               busy;
    logic               eoi_err;
    logic [IRQ_CNT-1:0] pending;

    modport master (
        input  irq, edge_sel, irq_en, ack, eoi, eoi_id,
        output valid, id, busy, eoi_err, pending
    );

    modport slave (
        output irq, edge_sel, irq_en, ack, eoi, eoi_id,
        input  valid, id, busy, eoi_err, pending
    );
endinterface

// File: rtl/ahb3lite_irq_arbiter.sv
// ahb3lite_irq_arbiter
//   Round-robin interrupt scheduler. Captures rising edges of edge-mode sources
//   into a pending register, follows level-mode sources directly, and offers one
//   vector at a time over a valid/ack handshake. An accepted vector stays active
//   until an end-of-interrupt carrying its id; only one vector is ever outstanding.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    arbiter side of ahb3lite_irq_arbiter_if (see interface header)
module ahb3lite_irq_arbiter #(
    parameter int unsigned IRQ_CNT = 240,
    parameter int unsigned ID_W    = $clog2(IRQ_CNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ahb3lite_irq_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StOffer, StActive} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IRQ_CNT-1:0] irq_q;
    logic [IRQ_CNT-1:0] pending_q, pending_d;
    logic               eoi_err_q, eoi_err_d;

    logic [IRQ_CNT-1:0] eligible;
    logic [IRQ_CNT-1:0] hi_mask;
    logic [IRQ_CNT-1:0] elig_hi;
    logic [IRQ_CNT-1:0] pend_set;
    logic [IRQ_CNT-1:0] pend_clr;
    logic [ID_W-1:0]    sel_id;
    logic               ack_fire;
    logic               eoi_ok;

    // Lowest set index of a vector (zero when empty; callers gate on |v).
    function automatic logic [ID_W-1:0] first_set(logic [IRQ_CNT-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = int'(IRQ_CNT) - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    // Eligibility is taken from registered state so a new request costs one
    // capture edge plus one selection edge before valid rises.
    always_comb begin
        eligible = bus.irq_en & ((bus.edge_sel & pending_q) | (~bus.edge_sel & irq_q));
        for (int i = 0; i < int'(IRQ_CNT); i++) begin
            hi_mask[i] = (ID_W'(i) >= rr_ptr_q);
        end
        elig_hi = eligible & hi_mask;
        // Search from rr_ptr upward first; fall back to the wrapped low part.
        sel_id  = (|elig_hi) ? first_set(elig_hi) : first_set(eligible);
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        ack_fire  = 1'b0;
        eoi_ok    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StOffer;
                    id_d    = sel_id;
                end
            end
            StOffer: begin
                // Offer is never withdrawn: only ack moves us on.
                if (bus.ack) begin
                    state_d  = StActive;
                    ack_fire = 1'b1;
                end
            end
            StActive: begin
                if (bus.eoi && (bus.eoi_id == id_q)) begin
                    state_d  = StIdle;
                    eoi_ok   = 1'b1;
                    rr_ptr_d = (id_q == ID_W'(IRQ_CNT - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any eoi that did not retire the active vector is reported.
        eoi_err_d = bus.eoi & ~eoi_ok;

        // A fresh edge in the same cycle as its ack wins over the clear.
        pend_set  = bus.edge_sel & bus.irq & ~irq_q;
        pend_clr  = ack_fire ? (IRQ_CNT'(1) << id_q) : '0;
        pending_d = pend_set | (pending_q & ~pend_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            id_q      <= '0;
            rr_ptr_q  <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            eoi_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            irq_q     <= bus.irq;
            pending_q <= pending_d;
            eoi_err_q <= eoi_err_d;
        end
    end

    assign bus.valid   = (state_q == StOffer);
    assign bus.busy    = (state_q == StActive);
    assign bus.id      = id_q;
    assign bus.eoi_err = eoi_err_q;
    assign bus.pending = pending_q;

endmodule
